fetch_pc_unit: RTL and testbench

//  Program-counter/fetch sequencer for the single-cycle core. Drives the instruction-ROM address.

---
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch sequencer: IDLE/RUN/HALT control, branch-target LUT, sticky wrap flag.
// Optional run-cycle counter output cycles_o enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_pc_unit #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [LUT_W-1:0] lut_idx_i,
  input  logic             halt_i,
  input  logic             lut_we_i,
  input  logic [LUT_W-1:0] lut_waddr_i,
  input  logic [PC_W-1:0]  lut_wdata_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             running_o,
  output logic             done_o,
  output logic             wrap_o
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycles_o
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int              LUT_DEPTH = 2 ** LUT_W;
  localparam logic [PC_W-1:0] PC_MAX    = '1;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            wrap_q, wrap_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
          wrap_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Stall outranks halt and branch; a halt holds the PC on the halt instruction.
        if (!stall_i) begin
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (branch_i) begin
            pc_d = lut_q[lut_idx_i];
          end else begin
            pc_d = pc_q + 1'b1;
            if (pc_q == PC_MAX) wrap_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  // NOTE: the LUT is reset to zero because programs may branch through unloaded entries;
  // reads are combinational, so a same-cycle write is only seen on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we_i) begin
      lut_q[lut_waddr_i] <= lut_wdata_i;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q != ST_RUN && start_i) begin
      cycles_d = '0;
    end else if (state_q == ST_RUN && cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif

  assign pc_o      = pc_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_HALT);
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch sequencer.
module tb_fetch_pc_unit;

  localparam int PC_W  = 10;
  localparam int LUT_W = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i, stall_i, branch_i, halt_i, lut_we_i;
  logic [LUT_W-1:0] lut_idx_i, lut_waddr_i;
  logic [PC_W-1:0]  lut_wdata_i;
  logic [PC_W-1:0]  pc_o;
  logic             running_o, done_o, wrap_o;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0]      cycles_o;
`endif

  fetch_pc_unit #(.PC_W(PC_W), .LUT_W(LUT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .branch_i    (branch_i),
    .lut_idx_i   (lut_idx_i),
    .halt_i      (halt_i),
    .lut_we_i    (lut_we_i),
    .lut_waddr_i (lut_waddr_i),
    .lut_wdata_i (lut_wdata_i),
    .pc_o        (pc_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .wrap_o      (wrap_o)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycles_o    (cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: plain integers and flags derived from the sequencing rules.
  int       m_pc;
  bit       m_running, m_done, m_wrap;
  int       m_lut [16];
  longint   m_cycles;

  function automatic logic [12:0] obs_vec();
    return {pc_o, running_o, done_o, wrap_o};
  endfunction

  function automatic logic [12:0] mdl_vec();
    logic [PC_W-1:0] p;
    p = m_pc[PC_W-1:0];
    return {p, m_running, m_done, m_wrap};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_running = 0; m_done = 0; m_wrap = 0; m_cycles = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic quiet_inputs();
    start_i = 0; stall_i = 0; branch_i = 0; halt_i = 0; lut_we_i = 0;
    lut_idx_i = '0; lut_waddr_i = '0; lut_wdata_i = '0;
  endtask

  // Advance one clock edge, update the model from the inputs that were presented,
  // and leave time 1 unit past the edge for sampling.
  task automatic step();
    bit was_running;
    @(posedge clk);
    was_running = m_running;
    if (m_running) begin
      if (!stall_i) begin
        if (halt_i) begin
          m_running = 0; m_done = 1;
        end else if (branch_i) begin
          m_pc = m_lut[lut_idx_i];
        end else begin
          if (m_pc == PC_MOD - 1) m_wrap = 1;
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end else if (start_i) begin
      m_running = 1; m_done = 0; m_pc = 0; m_wrap = 0;
    end
    if (!was_running && start_i) m_cycles = 0;
    else if (was_running && m_cycles < 64'hFFFF_FFFF) m_cycles++;
    if (lut_we_i) m_lut[lut_waddr_i] = int'(lut_wdata_i);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (obs_vec() !== 13'h0) begin fails++; $display("FAIL reset_state: got %h want %h", obs_vec(), 13'h0); end
    reset = 1;
    step();
    tests++; if (obs_vec() !== mdl_vec()) begin fails++; $display("FAIL idle_hold: got %h want %h", obs_vec(), mdl_vec()); end
  endtask

  task automatic test_sequential();
    start_i = 1;
    step();
    start_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd0 || running_o !== 1'b1) begin fails++; $display("FAIL start_pc0: got %h want %h", obs_vec(), mdl_vec()); end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++; if (obs_vec() !== mdl_vec() || pc_o !== PC_W'(i)) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", i, obs_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_branch();
    lut_we_i = 1; lut_waddr_i = 4'd3; lut_wdata_i = 10'h040;
    step();                         // pc 4
    lut_we_i = 0; start_i = 1;      // start in RUN must be ignored
    step();                         // pc 5
    start_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd5) begin fails++; $display("FAIL start_ignored_in_run: got %h want %h", obs_vec(), mdl_vec()); end
    branch_i = 1; lut_idx_i = 4'd3;
    step();
    branch_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'h040) begin fails++; $display("FAIL branch_target: got %h want %h", pc_o, 10'h040); end
    step();
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'h041) begin fails++; $display("FAIL branch_plus1: got %h want %h", pc_o, 10'h041); end
  endtask

  task automatic test_halt();
    lut_we_i = 1; lut_waddr_i = 4'd2; lut_wdata_i = 10'd7;
    step();
    lut_we_i = 0; branch_i = 1; lut_idx_i = 4'd2;
    step();
    branch_i = 0; halt_i = 1;
    tests++; if (pc_o !== 10'd7) begin fails++; $display("FAIL halt_setup_pc: got %h want %h", pc_o, 10'd7); end
    step();
    halt_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || done_o !== 1'b1 || running_o !== 1'b0 || pc_o !== 10'd7) begin fails++; $display("FAIL halt_enter: got %h want %h", obs_vec(), mdl_vec()); end
    branch_i = 1; lut_idx_i = 4'd3; stall_i = 1; halt_i = 1;
    step();
    branch_i = 0; stall_i = 0; halt_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd7 || done_o !== 1'b1) begin fails++; $display("FAIL halt_ignores_inputs: got %h want %h", obs_vec(), mdl_vec()); end
  endtask

  task automatic test_stall_priority();
    start_i = 1;
    step();
    start_i = 0;
    repeat (4) step();
    stall_i = 1; branch_i = 1; halt_i = 1; lut_idx_i = 4'd3;
    step();
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd4 || running_o !== 1'b1) begin fails++; $display("FAIL stall_priority: got %h want %h", obs_vec(), mdl_vec()); end
    stall_i = 0; branch_i = 0;
    lut_we_i = 1; lut_waddr_i = 4'd5; lut_wdata_i = 10'h3FF;
    step();                         // halt accepted
    halt_i = 0;
    lut_we_i = 1; lut_waddr_i = 4'd7; lut_wdata_i = 10'h155;   // LUT write while in HALT
    step();
    lut_we_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || done_o !== 1'b1 || pc_o !== 10'd4) begin fails++; $display("FAIL stall_release_halt: got %h want %h", obs_vec(), mdl_vec()); end
  endtask

  task automatic test_wrap();
    start_i = 1;
    step();
    start_i = 0; branch_i = 1; lut_idx_i = 4'd7;
    step();
    tests++; if (pc_o !== 10'h155) begin fails++; $display("FAIL lut_write_in_halt: got %h want %h", pc_o, 10'h155); end
    lut_idx_i = 4'd5;
    step();
    branch_i = 0;
    tests++; if (pc_o !== 10'h3FF || wrap_o !== 1'b0) begin fails++; $display("FAIL wrap_setup: got %h want %h", obs_vec(), mdl_vec()); end
    step();
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd0 || wrap_o !== 1'b1) begin fails++; $display("FAIL wrap_set: got %h want %h", obs_vec(), mdl_vec()); end
    halt_i = 1;
    step();
    halt_i = 0; start_i = 1;
    step();
    start_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || wrap_o !== 1'b0 || pc_o !== 10'd0) begin fails++; $display("FAIL wrap_clear_on_start: got %h want %h", obs_vec(), mdl_vec()); end
    branch_i = 1; lut_idx_i = 4'd6;  // unloaded entry, target 0
    step();
    branch_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || wrap_o !== 1'b0) begin fails++; $display("FAIL branch_to_zero_no_wrap: got %h want %h", obs_vec(), mdl_vec()); end
  endtask

  task automatic test_lut_same_cycle();
    lut_we_i = 1; lut_waddr_i = 4'd8; lut_wdata_i = 10'h123;
    branch_i = 1; lut_idx_i = 4'd8;
    step();
    lut_we_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd0) begin fails++; $display("FAIL lut_same_cycle_old: got %h want %h", pc_o, 10'd0); end
    step();
    branch_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'h123) begin fails++; $display("FAIL lut_next_cycle_new: got %h want %h", pc_o, 10'h123); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start_i     = ($urandom_range(99) < 6);
      stall_i     = ($urandom_range(99) < 20);
      branch_i    = ($urandom_range(99) < 15);
      halt_i      = ($urandom_range(99) < 3);
      lut_we_i    = ($urandom_range(99) < 20);
      lut_idx_i   = LUT_W'($urandom);
      lut_waddr_i = LUT_W'($urandom);
      lut_wdata_i = ($urandom_range(9) == 0) ? 10'h3FE : PC_W'($urandom);
      step();
      tests++; if (obs_vec() !== mdl_vec()) begin fails++; $display("FAIL random_cycle%0d: got %h want %h", n, obs_vec(), mdl_vec()); end
    end
    quiet_inputs();
  endtask

  task automatic test_async_reset();
    start_i = 1;
    step();
    start_i = 0;
    lut_we_i = 1; lut_waddr_i = 4'd9; lut_wdata_i = 10'h012;
    step();
    lut_we_i = 0; branch_i = 1; lut_idx_i = 4'd9;
    step();
    branch_i = 0;
    tests++; if (pc_o !== 10'h012 || running_o !== 1'b1) begin fails++; $display("FAIL async_setup: got %h want %h", obs_vec(), mdl_vec()); end
    #2;
    reset = 0;
    model_reset();
    #1;
    tests++; if (obs_vec() !== 13'h0) begin fails++; $display("FAIL async_reset: got %h want %h", obs_vec(), 13'h0); end
    @(negedge clk);
    reset = 1;
    start_i = 1;
    step();
    start_i = 0; branch_i = 1; lut_idx_i = 4'd9;
    step();
    branch_i = 0;
    tests++; if (obs_vec() !== mdl_vec() || pc_o !== 10'd0) begin fails++; $display("FAIL lut_cleared_by_reset: got %h want %h", pc_o, 10'd0); end
  endtask

`ifdef FETCH_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    reset = 0;
    quiet_inputs();
    model_reset();
    #1;
    tests++; if (cycles_o !== 32'd0) begin fails++; $display("FAIL cycles_reset: got %0d want 0", cycles_o); end
    @(negedge clk);
    reset = 1;
    start_i = 1;
    step();
    start_i = 0;
    repeat (5) step();
    halt_i = 1;
    step();
    halt_i = 0;
    repeat (2) step();
    tests++; if (cycles_o !== 32'(m_cycles) || cycles_o !== 32'd6) begin fails++; $display("FAIL cycles_frozen: got %0d want %0d", cycles_o, m_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_stall_priority();
    test_wrap();
    test_lut_same_cycle();
    test_random();
    test_async_reset();
`ifdef FETCH_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
